// File: rtl/wait_cycles_multi.sv
// Multi-channel cycle-count timer: each channel waits N+2 cycles after a start
// and emits a one-cycle completion pulse, optionally repeating every N+2 cycles.
module wait_cycles_multi #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*WIDTH-1:0] req_0,
  input  logic [NUM_CH-1:0]       req_mode,
  input  logic [NUM_CH-1:0]       req_cancel,
  output logic [NUM_CH-1:0]       req_ready,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q       [NUM_CH];
  state_t           state_d       [NUM_CH];
  logic [WIDTH-1:0] cycles_left_q [NUM_CH];
  logic [WIDTH-1:0] cycles_left_d [NUM_CH];
  logic [WIDTH-1:0] period_q      [NUM_CH];
  logic [WIDTH-1:0] period_d      [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic [NUM_CH-1:0] busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]       <= IDLE;
        cycles_left_q[i] <= '0;
        period_q[i]      <= '0;
      end
      mode_q  <= '0;
      hold_q  <= '0;
      ready_q <= '0;
      busy_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]       <= state_d[i];
        cycles_left_q[i] <= cycles_left_d[i];
        period_q[i]      <= period_d[i];
      end
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    hold_d  = hold_q;
    ready_d = '0;
    busy_d  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i]       = state_q[i];
      cycles_left_d[i] = cycles_left_q[i];
      period_d[i]      = period_q[i];
      case (state_q[i])
        IDLE: begin
          if (req_valid[i] && !req_cancel[i]) begin
            state_d[i]       = COUNT;
            cycles_left_d[i] = req_0[i*WIDTH +: WIDTH];
            period_d[i]      = req_0[i*WIDTH +: WIDTH];
            mode_d[i]        = req_mode[i];
            hold_d[i]        = 1'b1;
          end
        end
        COUNT: begin
          // A fresh start spends one extra COUNT cycle without decrementing, so
          // the first pulse lands at N+2 while periodic reloads keep an N+2 period
          // and an all-ones count never wraps early.
          if (req_cancel[i]) begin
            state_d[i] = IDLE;
          end else if (hold_q[i]) begin
            hold_d[i] = 1'b0;
          end else if (cycles_left_q[i] == '0) begin
            state_d[i] = DONE;
            ready_d[i] = 1'b1;
          end else begin
            cycles_left_d[i] = cycles_left_q[i] - WIDTH'(1);
          end
        end
        DONE: begin
          if (req_cancel[i]) begin
            state_d[i] = IDLE;
          end else if (mode_q[i]) begin
            state_d[i]       = COUNT;
            cycles_left_d[i] = period_q[i];
          end else begin
            state_d[i] = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
      busy_d[i] = (state_d[i] != IDLE);
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wait_cycles_multi.sv
// Bench for wait_cycles_multi: a start-time arithmetic model checks busy/req_ready
// of a 4x32 instance and a 1x4 instance every cycle, plus directed literal checks.
module tb_wait_cycles_multi;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid  = '0;
  logic [3:0]   req_mode   = '0;
  logic [3:0]   req_cancel = '0;
  logic [127:0] req_0      = '0;
  logic [3:0]   req_ready;
  logic [3:0]   busy;

  logic [0:0]   s_valid  = '0;
  logic [0:0]   s_mode   = '0;
  logic [0:0]   s_cancel = '0;
  logic [3:0]   s_cnt    = '0;
  logic [0:0]   s_ready;
  logic [0:0]   s_busy;

  wait_cycles_multi #(.WIDTH(32), .NUM_CH(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_0      (req_0),
    .req_mode   (req_mode),
    .req_cancel (req_cancel),
    .req_ready  (req_ready),
    .busy       (busy)
  );

  wait_cycles_multi #(.WIDTH(4), .NUM_CH(1)) u_small (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (s_valid),
    .req_0      (s_cnt),
    .req_mode   (s_mode),
    .req_cancel (s_cancel),
    .req_ready  (s_ready),
    .busy       (s_busy)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  longint ec = 0;

  // Model state per channel: channel 4 is the small instance.
  bit     m_act   [5];
  longint m_start [5];
  longint m_n     [5];
  bit     m_mode  [5];

  int     pcount      [5];
  longint first_pulse [5];
  longint last_pulse  [5];

  task automatic check(input string nm, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, ec);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 5; c++) begin
      pcount[c]      = 0;
      first_pulse[c] = -1;
      last_pulse[c]  = -1;
    end
  endtask

  // Returns at the falling edge just before rising edge number e.
  task automatic at_edge(input longint e);
    @(negedge clk);
    while (ec < e - 1) @(negedge clk);
  endtask

  always @(negedge rst) begin
    for (int c = 0; c < 5; c++) m_act[c] = 1'b0;
  end

  always @(posedge clk) begin
    logic   v, cn, md, ab, ar;
    longint n, d;
    bit     was_idle, er;
    ec = ec + 1;
    if (rst) begin
      for (int c = 0; c < 5; c++) begin
        v  = (c < 4) ? req_valid[c]  : s_valid[0];
        cn = (c < 4) ? req_cancel[c] : s_cancel[0];
        md = (c < 4) ? req_mode[c]   : s_mode[0];
        n  = (c < 4) ? longint'(req_0[c*32 +: 32]) : longint'(s_cnt);
        was_idle = !m_act[c];
        if (m_act[c]) begin
          d = ec - m_start[c];
          if (cn) m_act[c] = 1'b0;
          else if (!m_mode[c] && d >= m_n[c] + 3) m_act[c] = 1'b0;
        end
        if (was_idle && v && !cn) begin
          m_act[c]   = 1'b1;
          m_start[c] = ec;
          m_n[c]     = n;
          m_mode[c]  = md;
        end
      end
    end
    #1;
    for (int c = 0; c < 5; c++) begin
      d  = ec - m_start[c];
      er = m_act[c] && (d >= m_n[c] + 2) &&
           (m_mode[c] ? (((d - m_n[c] - 2) % (m_n[c] + 2)) == 0) : (d == m_n[c] + 2));
      ab = (c < 4) ? busy[c]      : s_busy[0];
      ar = (c < 4) ? req_ready[c] : s_ready[0];
      check($sformatf("busy[%0d]", c), longint'(ab), longint'(m_act[c]));
      check($sformatf("req_ready[%0d]", c), longint'(ar), longint'(er));
      if (ar) begin
        pcount[c]++;
        if (first_pulse[c] < 0) first_pulse[c] = ec;
        last_pulse[c] = ec;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ec);
    $fatal(1, "watchdog");
  end

  initial begin
    longint s;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_ready", longint'(req_ready), 0);
    check("rst_s_busy", longint'(s_busy), 0);
    check("rst_s_ready", longint'(s_ready), 0);
    rst = 1'b1;

    // One-shot ch0, N=5: pulse 7 edges after start.
    clear_stats();
    @(negedge clk);
    req_0[31:0] = 32'd5;
    req_valid   = 4'b0001;
    s = ec + 1;
    @(negedge clk);
    req_valid = '0;
    at_edge(s + 14);
    check("t1_latency", last_pulse[0] - s, 7);
    check("t1_pulses", pcount[0], 1);

    // Periodic ch1, N=3, cancelled at start+12.
    clear_stats();
    @(negedge clk);
    req_0[63:32] = 32'd3;
    req_mode     = 4'b0010;
    req_valid    = 4'b0010;
    s = ec + 1;
    @(negedge clk);
    req_valid = '0;
    at_edge(s + 12);
    req_cancel = 4'b0010;
    @(negedge clk);
    req_cancel = '0;
    at_edge(s + 20);
    check("t2_first", first_pulse[1] - s, 5);
    check("t2_last", last_pulse[1] - s, 10);
    check("t2_pulses", pcount[1], 2);
    check("t2_busy_after_cancel", longint'(busy[1]), 0);
    req_mode = '0;

    // ch2, N=0, valid held through COUNT: restart only at start+4.
    clear_stats();
    @(negedge clk);
    req_0[95:64] = 32'd0;
    req_valid    = 4'b0100;
    s = ec + 1;
    at_edge(s + 5);
    req_valid = '0;
    at_edge(s + 12);
    check("t3_first", first_pulse[2] - s, 2);
    check("t3_restart", last_pulse[2] - s, 6);
    check("t3_pulses", pcount[2], 2);

    // All channels one-shot with counts 1..4 started together.
    clear_stats();
    @(negedge clk);
    req_0     = {32'd4, 32'd3, 32'd2, 32'd1};
    req_valid = 4'b1111;
    s = ec + 1;
    @(negedge clk);
    req_valid = '0;
    at_edge(s + 12);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_lat%0d", i), first_pulse[i] - s, i + 3);
      check($sformatf("t4_cnt%0d", i), pcount[i], 1);
    end

    // Cancel beats valid while idle.
    @(negedge clk);
    req_valid  = 4'b0100;
    req_cancel = 4'b0100;
    @(negedge clk);
    req_valid  = '0;
    req_cancel = '0;
    check("t5_cancel_idle", longint'(busy[2]), 0);

    // Small instance, WIDTH=4, N=15: pulse 17 edges after start.
    clear_stats();
    @(negedge clk);
    s_cnt   = 4'd15;
    s_valid = 1'b1;
    s = ec + 1;
    @(negedge clk);
    s_valid = 1'b0;
    at_edge(s + 22);
    check("t6_wrap_latency", last_pulse[4] - s, 17);
    check("t6_pulses", pcount[4], 1);

    // Asynchronous reset mid-count and during a pulse.
    clear_stats();
    @(negedge clk);
    req_0[31:0]   = 32'd10;
    req_0[127:96] = 32'd0;
    req_mode      = 4'b1000;
    req_valid     = 4'b1001;
    s_cnt         = 4'd7;
    s_valid       = 1'b1;
    s = ec + 1;
    @(negedge clk);
    req_valid = '0;
    s_valid   = 1'b0;
    at_edge(s + 4);
    @(posedge clk);
    #3;
    check("t7_pre_busy0", longint'(busy[0]), 1);
    check("t7_pre_ready3", longint'(req_ready[3]), 1);
    check("t7_pre_s_busy", longint'(s_busy), 1);
    rst = 1'b0;
    #1;
    check("t7_async_busy", longint'(busy), 0);
    check("t7_async_ready", longint'(req_ready), 0);
    check("t7_async_s_busy", longint'(s_busy), 0);
    check("t7_async_s_ready", longint'(s_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_mode = '0;
    clear_stats();
    repeat (20) @(negedge clk);
    check("t7_no_pulse_after", pcount[0] + pcount[1] + pcount[2] + pcount[3] + pcount[4], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
